// File: rtl/risc_toy_mem_arbiter_if.sv
// Core-side bus of the RISC_TOY memory arbiter: fetch port and data port.
// The master modport is the core side and the slave modport is the arbiter side.
`default_nettype none

interface risc_toy_mem_arbiter_if #(
  parameter int BW = 32
);
  logic          i_req;
  logic [29:0]   i_addr;
  logic          i_gnt;
  logic          i_rvalid;
  logic [BW-1:0] i_rdata;

  logic          d_req;
  logic          d_rw;
  logic [29:0]   d_addr;
  logic [BW-1:0] d_wdata;
  logic          d_gnt;
  logic          d_rvalid;
  logic [BW-1:0] d_rdata;

  modport master (
    output i_req, i_addr, d_req, d_rw, d_addr, d_wdata,
    input  i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata
  );

  modport slave (
    input  i_req, i_addr, d_req, d_rw, d_addr, d_wdata,
    output i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata
  );
endinterface

`default_nettype wire

// File: rtl/risc_toy_mem_arbiter.sv
// ============================================================================
// Module : risc_toy_mem_arbiter
// Brief  : Single-port SRAM arbiter for the RISC_TOY fetch and data ports.
//          Data has priority, and a starvation counter forces fetch progress.
//          Optional statistics counters are enabled by RISC_TOY_ARB_STATS_EN.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module risc_toy_mem_arbiter #(
  parameter int AW           = 10,
  parameter int BW           = 32,
  parameter int STARVE_LIMIT = 3
) (
  input  wire logic            clk_i,
  input  wire logic            rstn_i,
  risc_toy_mem_arbiter_if.slave bus,
  output logic                 m_csn_o,
  output logic                 m_wen_o,
  output logic [AW-1:0]        m_a_o,
  output logic [BW-1:0]        m_di_o,
  input  wire logic [BW-1:0]   m_dout_i,
  output logic [15:0]          conflict_cnt_o,
  output logic [15:0]          starve_cnt_o
);

  localparam logic [3:0] C_LIMIT = 4'(STARVE_LIMIT);

  typedef enum logic [0:0] {ST_NORMAL = 1'b0, ST_FORCE_I = 1'b1} state_e;
  typedef enum logic [1:0] {TAG_NONE = 2'd0, TAG_I = 2'd1, TAG_D = 2'd2} tag_e;

  state_e        state_q, state_d;
  tag_e          tag_q, tag_d;
  logic [3:0]    starve_q, starve_d;
  logic [BW-1:0] i_rdata_q, d_rdata_q;
  logic          i_gnt_w, d_gnt_w;

  // Upper word-address bits lie outside the SRAM and are intentionally dropped.
  wire w_unused_addr = ^{bus.i_addr[29:AW], bus.d_addr[29:AW]};

  always_comb begin
    state_d  = state_q;
    starve_d = starve_q;
    i_gnt_w  = 1'b0;
    d_gnt_w  = 1'b0;
    if (rstn_i) begin
      case (state_q)
        ST_NORMAL: begin
          d_gnt_w = bus.d_req;
          i_gnt_w = bus.i_req & ~bus.d_req;
          if (bus.i_req && !i_gnt_w) begin
            starve_d = starve_q + 4'd1;
            if (starve_d >= C_LIMIT) state_d = ST_FORCE_I;
          end else begin
            starve_d = 4'd0;
          end
        end
        ST_FORCE_I: begin
          i_gnt_w  = bus.i_req;
          d_gnt_w  = bus.d_req & ~bus.i_req;
          starve_d = 4'd0;
          state_d  = ST_NORMAL;
        end
        default: begin
          state_d  = ST_NORMAL;
          starve_d = 4'd0;
        end
      endcase
    end
  end

  always_comb begin
    tag_d = TAG_NONE;
    if (i_gnt_w)                     tag_d = TAG_I;
    else if (d_gnt_w && !bus.d_rw)   tag_d = TAG_D;
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q   <= ST_NORMAL;
      starve_q  <= 4'd0;
      tag_q     <= TAG_NONE;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      tag_q    <= tag_d;
      if (tag_q == TAG_I) i_rdata_q <= m_dout_i;
      if (tag_q == TAG_D) d_rdata_q <= m_dout_i;
    end
  end

  assign bus.i_gnt    = i_gnt_w;
  assign bus.d_gnt    = d_gnt_w;
  assign bus.i_rvalid = (tag_q == TAG_I);
  assign bus.d_rvalid = (tag_q == TAG_D);
  // Unselected read-data port keeps showing its last delivered word.
  assign bus.i_rdata  = (tag_q == TAG_I) ? m_dout_i : i_rdata_q;
  assign bus.d_rdata  = (tag_q == TAG_D) ? m_dout_i : d_rdata_q;

  assign m_csn_o = ~(i_gnt_w | d_gnt_w);
  assign m_wen_o = ~(d_gnt_w & bus.d_rw);
  assign m_a_o   = i_gnt_w ? bus.i_addr[AW-1:0] : bus.d_addr[AW-1:0];
  assign m_di_o  = bus.d_wdata;

`ifdef RISC_TOY_ARB_STATS_EN
  logic [15:0] conflict_q, starve_cnt_q;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      conflict_q   <= 16'd0;
      starve_cnt_q <= 16'd0;
    end else begin
      if (bus.i_req && bus.d_req && conflict_q != 16'hFFFF)
        conflict_q <= conflict_q + 16'd1;
      if (state_q == ST_FORCE_I && i_gnt_w && starve_cnt_q != 16'hFFFF)
        starve_cnt_q <= starve_cnt_q + 16'd1;
    end
  end

  assign conflict_cnt_o = conflict_q;
  assign starve_cnt_o   = starve_cnt_q;
`else
  assign conflict_cnt_o = 16'd0;
  assign starve_cnt_o   = 16'd0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_risc_toy_mem_arbiter.sv
// Directed bench for risc_toy_mem_arbiter with a behavioural 1-cycle SRAM.
`default_nettype none

module tb_risc_toy_mem_arbiter;

  logic        clk = 1'b0;
  logic        rstn;
  logic        m_csn, m_wen;
  logic [9:0]  m_a;
  logic [31:0] m_di;
  logic [31:0] m_dout;
  logic [15:0] conflict_cnt, starve_cnt;
  logic [31:0] mem [0:1023];

  int n_assert = 0;
  int n_fail   = 0;

  risc_toy_mem_arbiter_if #(.BW(32)) bus ();

  risc_toy_mem_arbiter #(.AW(10), .BW(32), .STARVE_LIMIT(3)) dut (
    .clk_i          (clk),
    .rstn_i         (rstn),
    .bus            (bus),
    .m_csn_o        (m_csn),
    .m_wen_o        (m_wen),
    .m_a_o          (m_a),
    .m_di_o         (m_di),
    .m_dout_i       (m_dout),
    .conflict_cnt_o (conflict_cnt),
    .starve_cnt_o   (starve_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!m_csn) begin
      if (!m_wen) mem[m_a] <= m_di;
      m_dout <= mem[m_a];
    end
  end

`ifdef RISC_TOY_ARB_STATS_EN
  localparam logic [31:0] EXP_CONFLICT = 32'd8;
  localparam logic [31:0] EXP_STARVE   = 32'd2;
`else
  localparam logic [31:0] EXP_CONFLICT = 32'd0;
  localparam logic [31:0] EXP_STARVE   = 32'd0;
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Apply one cycle of requests just after a rising edge; checks follow at edge+3.
  task automatic drive(input logic ireq, input logic [29:0] iaddr, input logic dreq,
                       input logic drw, input logic [29:0] daddr, input logic [31:0] dwd);
    @(posedge clk);
    #1;
    bus.i_req   = ireq;
    bus.i_addr  = iaddr;
    bus.d_req   = dreq;
    bus.d_rw    = drw;
    bus.d_addr  = daddr;
    bus.d_wdata = dwd;
    #2;
  endtask

  initial begin
    logic exp_i [0:7];
    logic prev_i;
    logic [29:0] prev_a;

    for (int n = 0; n < 1024; n++) mem[n] = 32'h1000_0000 + n;
    m_dout      = '0;
    rstn        = 1'b0;
    bus.i_req   = 1'b0;
    bus.i_addr  = '0;
    bus.d_req   = 1'b0;
    bus.d_rw    = 1'b0;
    bus.d_addr  = '0;
    bus.d_wdata = '0;
    #12;
    chk("rst_i_rvalid", 32'(bus.i_rvalid), 32'd0);
    chk("rst_d_rvalid", 32'(bus.d_rvalid), 32'd0);
    chk("rst_csn", 32'(m_csn), 32'd1);
    chk("rst_wen", 32'(m_wen), 32'd1);
    @(posedge clk);
    #1 rstn = 1'b1;

    // Fetch-only stream, addresses 0..3
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 30'(k), 1'b0, 1'b0, 30'd0, 32'd0);
      chk("fetch_gnt", 32'(bus.i_gnt), 32'd1);
      chk("fetch_csn", 32'(m_csn), 32'd0);
      chk("fetch_addr", 32'(m_a), 32'(k));
      if (k > 0) begin
        chk("fetch_rvalid", 32'(bus.i_rvalid), 32'd1);
        chk("fetch_rdata", bus.i_rdata, 32'h1000_0000 + 32'(k - 1));
      end
    end
    drive(1'b0, 30'd0, 1'b0, 1'b0, 30'd0, 32'd0);
    chk("fetch_last_rvalid", 32'(bus.i_rvalid), 32'd1);
    chk("fetch_last_rdata", bus.i_rdata, 32'h1000_0003);
    chk("idle_gnt", 32'({bus.i_gnt, bus.d_gnt}), 32'd0);
    chk("idle_csn", 32'(m_csn), 32'd1);

    // Data write then read of the same word
    drive(1'b0, 30'd0, 1'b1, 1'b1, 30'd5, 32'hDEAD_BEEF);
    chk("wr_gnt", 32'(bus.d_gnt), 32'd1);
    chk("wr_wen", 32'(m_wen), 32'd0);
    chk("wr_di", m_di, 32'hDEAD_BEEF);
    chk("wr_addr", 32'(m_a), 32'd5);
    drive(1'b0, 30'd0, 1'b1, 1'b0, 30'd5, 32'd0);
    chk("rd_gnt", 32'(bus.d_gnt), 32'd1);
    chk("rd_wen", 32'(m_wen), 32'd1);
    chk("wr_no_rvalid", 32'(bus.d_rvalid), 32'd0);
    drive(1'b0, 30'd0, 1'b0, 1'b0, 30'd0, 32'd0);
    chk("rd_rvalid", 32'(bus.d_rvalid), 32'd1);
    chk("rd_rdata", bus.d_rdata, 32'hDEAD_BEEF);
    chk("rd_i_rdata_hold", bus.i_rdata, 32'h1000_0003);

    // Fresh reset so the statistics start from zero
    @(posedge clk);
    #1 rstn = 1'b0;
    #2 rstn = 1'b1;

    // Conflict with STARVE_LIMIT = 3: D D D I D D D I
    exp_i = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    prev_i = 1'b0;
    prev_a = '0;
    for (int k = 0; k < 8; k++) begin
      drive(1'b1, 30'(100 + k), 1'b1, 1'b0, 30'(200 + k), 32'd0);
      chk("cf_i_gnt", 32'(bus.i_gnt), 32'(exp_i[k]));
      chk("cf_d_gnt", 32'(bus.d_gnt), 32'(!exp_i[k]));
      if (k > 0) begin
        chk("cf_i_rvalid", 32'(bus.i_rvalid), 32'(prev_i));
        chk("cf_d_rvalid", 32'(bus.d_rvalid), 32'(!prev_i));
        chk("cf_rdata", prev_i ? bus.i_rdata : bus.d_rdata, 32'h1000_0000 + 32'(prev_a));
      end
      prev_i = exp_i[k];
      prev_a = exp_i[k] ? 30'(100 + k) : 30'(200 + k);
    end
    drive(1'b0, 30'd0, 1'b0, 1'b0, 30'd0, 32'd0);
    chk("cf_last_i_rvalid", 32'(bus.i_rvalid), 32'd1);
    chk("cf_last_rdata", bus.i_rdata, 32'h1000_0000 + 32'd107);
    chk("stat_conflict", 32'(conflict_cnt), EXP_CONFLICT);
    chk("stat_starve", 32'(starve_cnt), EXP_STARVE);

    // Starvation counter clears when I_REQ drops for a cycle
    exp_i = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    for (int k = 0; k < 7; k++) begin
      drive((k != 2), 30'd50, 1'b1, 1'b0, 30'd300, 32'd0);
      chk("sv_i_gnt", 32'(bus.i_gnt), 32'(exp_i[k]));
      chk("sv_d_gnt", 32'(bus.d_gnt), 32'(!exp_i[k]));
    end
    drive(1'b0, 30'd0, 1'b0, 1'b0, 30'd0, 32'd0);

    // Reset while a data read is in flight
    drive(1'b0, 30'd0, 1'b1, 1'b0, 30'd7, 32'd0);
    chk("mr_gnt", 32'(bus.d_gnt), 32'd1);
    #1 rstn = 1'b0;
    #2;
    chk("mr_csn", 32'(m_csn), 32'd1);
    chk("mr_wen", 32'(m_wen), 32'd1);
    chk("mr_gnt_in_rst", 32'(bus.d_gnt), 32'd0);
    @(posedge clk);
    #1;
    chk("mr_rvalid_in_rst", 32'(bus.d_rvalid), 32'd0);
    bus.d_req = 1'b0;
    rstn = 1'b1;
    @(posedge clk);
    #1;
    chk("mr_rvalid_after", 32'(bus.d_rvalid), 32'd0);
    chk("mr_i_rvalid_after", 32'(bus.i_rvalid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
